ip_rx_filter_64: RTL and testbench

- Sits directly downstream of the ip_64 receive output (m_ip_* stream), upstream of the UDP/ICMP consumers.
- Accepts only IPv4 frames addressed to this host: unicast to local_ip, plus optional limited/directed broadcast and multicast.
- Forwards matching frames unchanged at full 64-bit throughput; silently discards the rest and counts them.

---
 rtl/ip_pkg.sv | 45 ++++
 rtl/axis_skid_buffer_64.sv | 69 ++++++
 rtl/ip_rx_filter_64.sv | 160 ++++++++++++++++
 tb/tb_ip_rx_filter_64.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ip_pkg.sv
// Shared constants, types and the destination-match rule for the IPv4 receive filter.
package ip_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned KEEP_W = 8;
    localparam int unsigned ADDR_W = 32;

    localparam logic [ADDR_W-1:0] IPV4_BCAST   = 32'hFFFF_FFFF;
    localparam logic [3:0]        MCAST_PREFIX = 4'hE;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FORWARD = 2'd1,
        ST_DROP    = 2'd2
    } filt_state_e;

    typedef struct packed {
        logic [15:0]       length;
        logic [7:0]        ttl;
        logic [7:0]        protocol;
        logic [ADDR_W-1:0] source_ip;
        logic [ADDR_W-1:0] dest_ip;
    } ip_hdr_t;

    typedef struct packed {
        logic [DATA_W-1:0] tdata;
        logic [KEEP_W-1:0] tkeep;
        logic              tlast;
        logic              tuser;
    } axis_beat_t;

    // True when a frame to dest is for this host (unicast, broadcast or multicast).
    function automatic logic dest_match(input logic [ADDR_W-1:0] dest,
                                        input logic [ADDR_W-1:0] local_ip,
                                        input logic [ADDR_W-1:0] subnet_mask,
                                        input logic              en_bcast,
                                        input logic              en_mcast);
        logic ucast, bcast, mcast;
        ucast = (dest == local_ip) && (dest != '0);
        bcast = en_bcast && ((dest == IPV4_BCAST) || (dest == (local_ip | ~subnet_mask)));
        mcast = en_mcast && (dest[ADDR_W-1:ADDR_W-4] == MCAST_PREFIX);
        return ucast || bcast || mcast;
    endfunction

endpackage

// File: rtl/axis_skid_buffer_64.sv
// Two-entry AXI-stream skid buffer: registered output beat plus one overflow slot.
module axis_skid_buffer_64
    import ip_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_valid,
    output logic       s_ready,
    input  axis_beat_t s_beat,
    output logic       m_valid,
    input  logic       m_ready,
    output axis_beat_t m_beat
);

    logic       out_valid_q, out_valid_d;
    logic       skid_valid_q, skid_valid_d;
    logic       ready_q, ready_d;
    axis_beat_t out_beat_q, out_beat_d;
    axis_beat_t skid_beat_q, skid_beat_d;
    logic       push;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_beat_d   = out_beat_q;
        skid_valid_d = skid_valid_q;
        skid_beat_d  = skid_beat_q;
        push         = s_valid && ready_q;

        if (!out_valid_q || m_ready) begin
            // Output slot frees up: refill from the skid slot first to keep order.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_beat_d   = skid_beat_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = push;
                if (push) begin
                    out_beat_d = s_beat;
                end
            end
        end else if (push) begin
            skid_valid_d = 1'b1;
            skid_beat_d  = s_beat;
        end

        ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b0;
            out_beat_q   <= '0;
            skid_beat_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ready_d;
            out_beat_q   <= out_beat_d;
            skid_beat_q  <= skid_beat_d;
        end
    end

    assign s_ready = ready_q;
    assign m_valid = out_valid_q;
    assign m_beat  = out_beat_q;

endmodule

// File: rtl/ip_rx_filter_64.sv
// IPv4 receive filter: forwards frames addressed to this host, discards and counts the rest.
module ip_rx_filter_64
    import ip_pkg::*;
#(
    parameter bit          ENABLE_BROADCAST = 1'b1,
    parameter bit          ENABLE_MULTICAST = 1'b0,
    parameter int unsigned DROP_COUNT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        s_ip_hdr_valid,
    output logic                        s_ip_hdr_ready,
    input  logic [15:0]                 s_ip_length,
    input  logic [7:0]                  s_ip_ttl,
    input  logic [7:0]                  s_ip_protocol,
    input  logic [31:0]                 s_ip_source_ip,
    input  logic [31:0]                 s_ip_dest_ip,
    input  logic [63:0]                 s_ip_payload_axis_tdata,
    input  logic [7:0]                  s_ip_payload_axis_tkeep,
    input  logic                        s_ip_payload_axis_tvalid,
    input  logic                        s_ip_payload_axis_tlast,
    input  logic                        s_ip_payload_axis_tuser,
    output logic                        s_ip_payload_axis_tready,
    output logic                        m_ip_hdr_valid,
    input  logic                        m_ip_hdr_ready,
    output logic [15:0]                 m_ip_length,
    output logic [7:0]                  m_ip_ttl,
    output logic [7:0]                  m_ip_protocol,
    output logic [31:0]                 m_ip_source_ip,
    output logic [31:0]                 m_ip_dest_ip,
    output logic [63:0]                 m_ip_payload_axis_tdata,
    output logic [7:0]                  m_ip_payload_axis_tkeep,
    output logic                        m_ip_payload_axis_tvalid,
    output logic                        m_ip_payload_axis_tlast,
    output logic                        m_ip_payload_axis_tuser,
    input  logic                        m_ip_payload_axis_tready,
    input  logic [31:0]                 local_ip,
    input  logic [31:0]                 subnet_mask,
    output logic                        busy,
    output logic                        drop_pulse,
    output logic [DROP_COUNT_WIDTH-1:0] drop_count
);

    localparam logic [DROP_COUNT_WIDTH-1:0] DROP_MAX = {DROP_COUNT_WIDTH{1'b1}};

    filt_state_e                 state_q, state_d;
    ip_hdr_t                     hdr_q, hdr_d;
    logic                        hdr_valid_q, hdr_valid_d;
    logic                        hdr_ready_q, hdr_ready_d;
    logic                        busy_q, busy_d;
    logic                        drop_pulse_q, drop_pulse_d;
    logic [DROP_COUNT_WIDTH-1:0] drop_count_q, drop_count_d;

    logic       hdr_fire, hdr_match, pay_fire, tready_c, buf_s_valid, buf_s_ready;
    axis_beat_t in_beat, out_beat;

    assign in_beat = {s_ip_payload_axis_tdata, s_ip_payload_axis_tkeep,
                      s_ip_payload_axis_tlast, s_ip_payload_axis_tuser};

    always_comb begin
        state_d      = state_q;
        hdr_d        = hdr_q;
        hdr_valid_d  = hdr_valid_q;
        drop_pulse_d = 1'b0;
        drop_count_d = drop_count_q;

        unique case (state_q)
            ST_FORWARD: tready_c = buf_s_ready;
            ST_DROP:    tready_c = 1'b1;
            default:    tready_c = 1'b0;
        endcase

        buf_s_valid = s_ip_payload_axis_tvalid && (state_q == ST_FORWARD);
        pay_fire    = s_ip_payload_axis_tvalid && tready_c;
        hdr_fire    = s_ip_hdr_valid && hdr_ready_q;
        hdr_match   = dest_match(s_ip_dest_ip, local_ip, subnet_mask,
                                 ENABLE_BROADCAST, ENABLE_MULTICAST);

        if (hdr_valid_q && m_ip_hdr_ready) begin
            hdr_valid_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (hdr_fire) begin
                    if (hdr_match) begin
                        hdr_d       = {s_ip_length, s_ip_ttl, s_ip_protocol,
                                       s_ip_source_ip, s_ip_dest_ip};
                        hdr_valid_d = 1'b1;
                        state_d     = ST_FORWARD;
                    end else begin
                        drop_pulse_d = 1'b1;
                        if (drop_count_q != DROP_MAX) begin
                            drop_count_d = drop_count_q + DROP_COUNT_WIDTH'(1);
                        end
                        state_d = ST_DROP;
                    end
                end
            end
            ST_FORWARD, ST_DROP: begin
                if (pay_fire && s_ip_payload_axis_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Header ready is registered, so it already excludes the cycle a frame ends.
        hdr_ready_d = (state_d == ST_IDLE) && !hdr_valid_d;
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            hdr_q        <= '0;
            hdr_valid_q  <= 1'b0;
            hdr_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            drop_pulse_q <= 1'b0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            hdr_q        <= hdr_d;
            hdr_valid_q  <= hdr_valid_d;
            hdr_ready_q  <= hdr_ready_d;
            busy_q       <= busy_d;
            drop_pulse_q <= drop_pulse_d;
            drop_count_q <= drop_count_d;
        end
    end

    axis_skid_buffer_64 u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (buf_s_valid),
        .s_ready (buf_s_ready),
        .s_beat  (in_beat),
        .m_valid (m_ip_payload_axis_tvalid),
        .m_ready (m_ip_payload_axis_tready),
        .m_beat  (out_beat)
    );

    assign s_ip_hdr_ready           = hdr_ready_q;
    assign s_ip_payload_axis_tready = tready_c;
    assign m_ip_hdr_valid           = hdr_valid_q;
    assign m_ip_length              = hdr_q.length;
    assign m_ip_ttl                 = hdr_q.ttl;
    assign m_ip_protocol            = hdr_q.protocol;
    assign m_ip_source_ip           = hdr_q.source_ip;
    assign m_ip_dest_ip             = hdr_q.dest_ip;
    assign m_ip_payload_axis_tdata  = out_beat.tdata;
    assign m_ip_payload_axis_tkeep  = out_beat.tkeep;
    assign m_ip_payload_axis_tlast  = out_beat.tlast;
    assign m_ip_payload_axis_tuser  = out_beat.tuser;
    assign busy                     = busy_q;
    assign drop_pulse               = drop_pulse_q;
    assign drop_count               = drop_count_q;

endmodule

// File: tb/tb_ip_rx_filter_64.sv
// Randomized bench for ip_rx_filter_64: two parameterizations checked against a queue-based model.
module tb_ip_rx_filter_64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        hdr_valid = 1'b0;
    logic [15:0] len = '0;
    logic [7:0]  ttl = '0, proto = '0;
    logic [31:0] src = '0, dst = '0;
    logic [63:0] tdata = '0;
    logic [7:0]  tkeep = '0;
    logic        tvalid = 1'b0, tlast = 1'b0, tuser = 1'b0;
    logic        m_hdr_ready = 1'b0, m_tready = 1'b0;
    logic [31:0] local_ip = 32'hC0A8_0180, subnet_mask = 32'hFFFF_FF00;

    logic        h_rdy [2], t_rdy [2], mhv [2], mtv [2], mtl [2], mtu [2], bsy [2], dp [2];
    logic [15:0] mlen [2];
    logic [7:0]  mttl [2], mpro [2], mtk [2];
    logic [31:0] msrc [2], mdst [2];
    logic [63:0] mtd [2];
    logic [15:0] dc0;
    logic [1:0]  dc1;

    ip_rx_filter_64 #(.ENABLE_BROADCAST(1'b1), .ENABLE_MULTICAST(1'b0), .DROP_COUNT_WIDTH(16)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .s_ip_hdr_valid(hdr_valid & ~sel), .s_ip_hdr_ready(h_rdy[0]),
        .s_ip_length(len), .s_ip_ttl(ttl), .s_ip_protocol(proto), .s_ip_source_ip(src), .s_ip_dest_ip(dst),
        .s_ip_payload_axis_tdata(tdata), .s_ip_payload_axis_tkeep(tkeep),
        .s_ip_payload_axis_tvalid(tvalid & ~sel), .s_ip_payload_axis_tlast(tlast),
        .s_ip_payload_axis_tuser(tuser), .s_ip_payload_axis_tready(t_rdy[0]),
        .m_ip_hdr_valid(mhv[0]), .m_ip_hdr_ready(m_hdr_ready),
        .m_ip_length(mlen[0]), .m_ip_ttl(mttl[0]), .m_ip_protocol(mpro[0]),
        .m_ip_source_ip(msrc[0]), .m_ip_dest_ip(mdst[0]),
        .m_ip_payload_axis_tdata(mtd[0]), .m_ip_payload_axis_tkeep(mtk[0]),
        .m_ip_payload_axis_tvalid(mtv[0]), .m_ip_payload_axis_tlast(mtl[0]),
        .m_ip_payload_axis_tuser(mtu[0]), .m_ip_payload_axis_tready(m_tready),
        .local_ip(local_ip), .subnet_mask(subnet_mask),
        .busy(bsy[0]), .drop_pulse(dp[0]), .drop_count(dc0)
    );

    ip_rx_filter_64 #(.ENABLE_BROADCAST(1'b0), .ENABLE_MULTICAST(1'b1), .DROP_COUNT_WIDTH(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .s_ip_hdr_valid(hdr_valid & sel), .s_ip_hdr_ready(h_rdy[1]),
        .s_ip_length(len), .s_ip_ttl(ttl), .s_ip_protocol(proto), .s_ip_source_ip(src), .s_ip_dest_ip(dst),
        .s_ip_payload_axis_tdata(tdata), .s_ip_payload_axis_tkeep(tkeep),
        .s_ip_payload_axis_tvalid(tvalid & sel), .s_ip_payload_axis_tlast(tlast),
        .s_ip_payload_axis_tuser(tuser), .s_ip_payload_axis_tready(t_rdy[1]),
        .m_ip_hdr_valid(mhv[1]), .m_ip_hdr_ready(m_hdr_ready),
        .m_ip_length(mlen[1]), .m_ip_ttl(mttl[1]), .m_ip_protocol(mpro[1]),
        .m_ip_source_ip(msrc[1]), .m_ip_dest_ip(mdst[1]),
        .m_ip_payload_axis_tdata(mtd[1]), .m_ip_payload_axis_tkeep(mtk[1]),
        .m_ip_payload_axis_tvalid(mtv[1]), .m_ip_payload_axis_tlast(mtl[1]),
        .m_ip_payload_axis_tuser(mtu[1]), .m_ip_payload_axis_tready(m_tready),
        .local_ip(local_ip), .subnet_mask(subnet_mask),
        .busy(bsy[1]), .drop_pulse(dp[1]), .drop_count(dc1)
    );

    logic [15:0] cur_dc;
    assign cur_dc = sel ? 16'(dc1) : dc0;

    // Reference model state: frame phase 0 idle / 1 forward / 2 drop, plus expected queues.
    int          nvec = 0, nerr = 0, n_out_beats = 0;
    int          mphase = 0;
    bit          exp_hv = 1'b0, pend_drop = 1'b0, after_rst = 1'b1;
    int          exp_cnt [2] = '{0, 0};
    logic [95:0] hq [$];
    logic [73:0] bq [$];
    int          rmode = 0;

    localparam bit MDL_BC [2] = '{1'b1, 1'b0};
    localparam bit MDL_MC [2] = '{1'b0, 1'b1};
    localparam int MDL_MAX [2] = '{65535, 3};

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string nm);
        nvec++;
        nerr++;
        $display("FAIL %s: handshake not seen, required within 300 cycles (t=%0t)", nm, $time);
    endtask

    function automatic bit ref_match(input logic [31:0] d, input int s);
        if (d == local_ip && d != 32'h0) return 1'b1;
        if (MDL_BC[s] && (d == 32'hFFFF_FFFF || d == (local_ip | ~subnet_mask))) return 1'b1;
        if (MDL_MC[s] && d[31:28] == 4'hE) return 1'b1;
        return 1'b0;
    endfunction

    // Output backpressure generator.
    always @(posedge clk) begin
        #1;
        case (rmode)
            0: begin m_tready = 1'b1; m_hdr_ready = 1'b1; end
            1: begin m_tready = ~m_tready; m_hdr_ready = 1'b1; end
            default: begin
                m_tready    = ($urandom_range(0, 3) != 0);
                m_hdr_ready = $urandom_range(0, 1) != 0;
            end
        endcase
    end

    // Compare process: checks current outputs, then advances the model by the coming edge.
    initial begin
        bit e_tready, e_tvalid, e_hready, m;
        int s;
        @(posedge clk);
        forever begin
            @(negedge clk);
            s        = int'(sel);
            e_tready = (mphase == 1) ? (bq.size() < 2) : (mphase == 2);
            e_tvalid = (bq.size() > 0);
            e_hready = (mphase == 0) && !exp_hv && !after_rst;
            if (pend_drop && exp_cnt[s] < MDL_MAX[s]) exp_cnt[s]++;

            chk("busy", 96'(bsy[sel]), 96'(mphase != 0));
            chk("m_hdr_valid", 96'(mhv[sel]), 96'(exp_hv));
            chk("s_hdr_ready", 96'(h_rdy[sel]), 96'(e_hready));
            chk("s_tready", 96'(t_rdy[sel]), 96'(e_tready));
            chk("m_tvalid", 96'(mtv[sel]), 96'(e_tvalid));
            chk("drop_pulse", 96'(dp[sel]), 96'(pend_drop));
            chk("drop_count", 96'(cur_dc), 96'(exp_cnt[s]));

            if (exp_hv && m_hdr_ready && hq.size() > 0)
                chk("hdr_out", {mlen[sel], mttl[sel], mpro[sel], msrc[sel], mdst[sel]}, hq.pop_front());
            if (e_tvalid && m_tready) begin
                chk("beat_out", 96'({mtd[sel], mtk[sel], mtl[sel], mtu[sel]}), 96'(bq.pop_front()));
                n_out_beats++;
            end

            pend_drop = 1'b0;
            after_rst = 1'b0;
            if (!rst_n) begin
                mphase    = 0;
                exp_hv    = 1'b0;
                after_rst = 1'b1;
                hq.delete();
                bq.delete();
                exp_cnt   = '{0, 0};
            end else begin
                if (exp_hv && m_hdr_ready) exp_hv = 1'b0;
                if (tvalid && e_tready) begin
                    if (mphase == 1) bq.push_back({tdata, tkeep, tlast, tuser});
                    if (tlast) mphase = 0;
                end
                if (hdr_valid && e_hready) begin
                    m = ref_match(dst, s);
                    if (m) begin
                        hq.push_back({len, ttl, proto, src, dst});
                        exp_hv = 1'b1;
                        mphase = 1;
                    end else begin
                        pend_drop = 1'b1;
                        mphase    = 2;
                    end
                end
            end
        end
    end

    task automatic send_frame(input logic [31:0] d, input int nb, input logic [7:0] lastkeep,
                              input logic lastuser, input bit gaps, input int abort_at);
        int t;
        len   = 16'(20 + nb * 8);
        ttl   = 8'($urandom);
        proto = 8'd17;
        src   = $urandom;
        dst   = d;
        hdr_valid = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (h_rdy[sel] !== 1'b1 && t < 300);
        if (t >= 300) begin
            timeout_fail("hdr_handshake");
            hdr_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        hdr_valid = 1'b0;
        for (int i = 0; i < nb; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                @(posedge clk); #1;
            end
            tdata  = {$urandom, $urandom};
            tkeep  = (i == nb - 1) ? lastkeep : 8'hFF;
            tlast  = (i == nb - 1);
            tuser  = (i == nb - 1) ? lastuser : 1'b0;
            tvalid = 1'b1;
            if (i == abort_at) begin
                rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n  = 1'b1;
                tvalid = 1'b0;
                tlast  = 1'b0;
                return;
            end
            t = 0;
            do begin @(negedge clk); t++; end while (t_rdy[sel] !== 1'b1 && t < 300);
            if (t >= 300) begin
                timeout_fail("beat_handshake");
                tvalid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            tvalid = 1'b0;
            tlast  = 1'b0;
        end
    endtask

    task automatic drain();
        int t = 0;
        do begin @(negedge clk); t++; end
        while (!(mphase == 0 && !exp_hv && bq.size() == 0 && hq.size() == 0) && t < 300);
        if (t >= 300) timeout_fail("drain");
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        logic [31:0] d;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_drop_count", 96'(cur_dc), 96'd0);
        chk("rst_hdr_valid", 96'(mhv[0]), 96'd0);
        chk("rst_hdr_ready", 96'(h_rdy[0]), 96'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        base = n_out_beats;
        send_frame(32'hC0A8_0180, 3, 8'h0F, 1'b0, 1'b0, -1);
        drain();
        chk("unicast_beats", 96'(n_out_beats - base), 96'd3);
        chk("unicast_drops", 96'(cur_dc), 96'd0);

        send_frame(32'hC0A8_0181, 2, 8'hFF, 1'b0, 1'b0, -1);
        drain();
        chk("miss_drops", 96'(cur_dc), 96'd1);

        base = n_out_beats;
        send_frame(32'hFFFF_FFFF, 2, 8'h03, 1'b0, 1'b0, -1);
        send_frame(32'hC0A8_01FF, 2, 8'h01, 1'b1, 1'b0, -1);
        drain();
        chk("bcast_beats", 96'(n_out_beats - base), 96'd4);
        chk("bcast_drops", 96'(cur_dc), 96'd1);

        rmode = 1;
        base  = n_out_beats;
        send_frame(32'hC0A8_0180, 8, 8'h7F, 1'b1, 1'b0, -1);
        drain();
        chk("stall_beats", 96'(n_out_beats - base), 96'd8);

        rmode = 0;
        send_frame(32'hC0A8_0180, 6, 8'hFF, 1'b0, 1'b0, 2);
        chk("rst_mid_busy", 96'(bsy[0]), 96'd0);
        chk("rst_mid_tvalid", 96'(mtv[0]), 96'd0);
        chk("rst_mid_dest", 96'(mdst[0]), 96'd0);
        chk("rst_mid_drops", 96'(cur_dc), 96'd0);
        base = n_out_beats;
        send_frame(32'hC0A8_0180, 2, 8'hFF, 1'b0, 1'b0, -1);
        drain();
        chk("post_rst_beats", 96'(n_out_beats - base), 96'd2);

        rmode = 2;
        for (int f = 0; f < 40; f++) begin
            case ($urandom_range(0, 6))
                0, 1:    d = local_ip;
                2:       d = local_ip + 32'd1;
                3:       d = 32'hFFFF_FFFF;
                4:       d = local_ip | ~subnet_mask;
                5:       d = {4'hE, 28'($urandom)};
                default: d = $urandom;
            endcase
            send_frame(d, $urandom_range(1, 6), 8'($urandom_range(1, 255)), 1'($urandom), 1'b1, -1);
        end
        drain();

        rmode = 0;
        sel   = 1'b1;
        @(posedge clk); #1;
        send_frame(32'hFFFF_FFFF, 2, 8'hFF, 1'b0, 1'b0, -1);
        send_frame(32'hC0A8_01FF, 1, 8'hFF, 1'b0, 1'b0, -1);
        drain();
        chk("nobcast_drops", 96'(cur_dc), 96'd2);
        base = n_out_beats;
        send_frame(32'hE000_00FB, 1, 8'h3F, 1'b1, 1'b0, -1);
        drain();
        chk("mcast_beats", 96'(n_out_beats - base), 96'd1);
        local_ip    = 32'h0;
        subnet_mask = 32'hFFFF_FFFF;
        send_frame(32'h0, 1, 8'hFF, 1'b0, 1'b0, -1);
        drain();
        local_ip    = 32'hC0A8_0180;
        subnet_mask = 32'hFFFF_FF00;
        send_frame(32'hC0A8_0181, 2, 8'hFF, 1'b0, 1'b0, -1);
        send_frame(32'hC0A8_0182, 1, 8'hFF, 1'b0, 1'b0, -1);
        drain();
        chk("sat_drops", 96'(cur_dc), 96'd3);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

endmodule
